vga_frame_fetch: RTL and testbench
==================================

Name: vga_frame_fetch

Overview:
- Parametrised AXI4 read master that streams a framebuffer from DDR2 (MIG AXI slave) into an on-chip pixel FIFO feeding the VGA output pipeline.
- Successor to the fixed single-burst fetch in the VGA design. Generalised in data width, burst length, FIFO depth and outstanding-read count.
- Adds line-pitch addressing, start-of-line and end-of-frame tagging, and underrun and error reporting.
- Single clock domain: the MIG ui clock.

Parameters:
DATA_W, 32, AXI read data and pixel word width; 32/64/128.
BURST_LEN, 16, maximum beats per AR burst; power of 2, ≤256, BURST_LEN*DATA_W/8 ≤ 4096.
FIFO_DEPTH, 256, pixel FIFO words; power of 2, ≥ 2*BURST_LEN.
MAX_OUTST, 2, maximum AR bursts outstanding; 1..4.
ARID, 0, constant value driven on mem_arid.

Ports:
clk  in  1  ui clock
cpu_resetn  in  1  asynchronous active-low reset
frame_start  in  1  pulse: begin fetching one frame
frame_base  in  32  byte address of line 0
line_pitch  in  32  byte stride between lines
line_words  in  12  DATA_W words per line, ≥1
num_lines  in  12  lines per frame, ≥1
busy  out  1  frame in progress
mem_arid  out  8  = ARID
mem_araddr  out  32  burst address
mem_arlen  out  8  beats-1
mem_arsize  out  3  log2(DATA_W/8)
mem_arburst  out  2  2'b01 INCR
mem_arlock  out  1  0
mem_arvalid  out  1  AR valid
mem_arready  in  1  AR ready
mem_rid  in  8  ignored
mem_rdata  in  DATA_W  read data
mem_rresp  in  2  response
mem_rlast  in  1  last beat
mem_rvalid  in  1  R valid
mem_rready  out  1  R ready
pix_data  out  DATA_W  FIFO head
pix_sol  out  1  head is first word of a line
pix_eof  out  1  head is last word of frame
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  consumer pop
underrun  out  1  sticky
rd_err  out  1  sticky
frame_overrun  out  1  sticky

Behaviour:
- Reset: all outputs 0 except the constants mem_arsize, mem_arburst and mem_arid. FIFO empty, FSM in IDLE, all counters cleared. Sticky flags clear only on reset.
- Constraints: frame_base and line_pitch must be aligned to BURST_LEN*DATA_W/8 bytes. Under that alignment no burst crosses a 4 KB boundary.
- FSM states:
  - IDLE: on frame_start, latch all config inputs, set busy, load line=0, word=0, go to ISSUE.
  - ISSUE: beats = min(BURST_LEN, line_words-word).
    - Raise arvalid when outstanding<MAX_OUTST and fifo_count+reserved+beats ≤ FIFO_DEPTH.
    - araddr = frame_base + line*line_pitch + word*DATA_W/8, computed incrementally (no multiplier); arlen = beats-1.
    - AR signals hold stable until arready.
    - On handshake: reserved+=beats, outstanding++, advance word. At end of line: word=0, line++.
    - After the final burst of the frame, go to DRAIN.
  - DRAIN: wait until outstanding==0, then clear busy and go to IDLE. busy falls the cycle after the last rlast handshake.
- R channel:
  - mem_rready = 1 whenever busy; the reservation guarantees FIFO space.
  - Each beat pushes {rdata, sol, eof}. reserved--.
  - On rlast: outstanding--.
  - sol/eof come from a separate beat counter over returned data; in-order return is guaranteed (single ID).
- rresp≠0: set rd_err, push the data anyway.
- Pixel FIFO: first-word-fall-through. Pop on pix_valid&pix_ready. Simultaneous push and pop keeps fifo_count unchanged. Push-to-pix_valid latency is 1 cycle.
- underrun: set when busy & pix_ready & ~pix_valid.
- frame_start while busy is ignored and sets frame_overrun.
- AR and R handshakes in the same cycle: outstanding is net-updated (++ and -- cancel).
- Reset asserted mid-burst: immediate return to IDLE. The system resets the MIG together with this block.

Optional Feature:
- Macro: VGA_FRAME_FETCH_STATS_EN.
- Defined: adds outputs stat_bursts (32 bit), stat_underruns (16 bit, saturating) and stat_max_lat (16 bit).
  - stat_bursts counts AR handshakes.
  - stat_underruns counts underrun cycles.
  - stat_max_lat is the maximum number of cycles from an AR handshake to its first R beat.
  - All three are cleared on frame_start accepted in IDLE.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Defaults; base=0x1000, pitch=0x400, line_words=640, num_lines=2; slave with 5-cycle latency; pix_ready=1 after FIFO full → 80 bursts all arlen=15; addresses 0x1000.. then 0x1400..; pix_sol on words 0 and 640; pix_eof on word 1279; busy falls; no flags set.
- line_words=20 → per line, bursts with arlen 15 then 3; second line starts at base+pitch.
- pix_ready=0 for the whole frame, FIFO_DEPTH=256 → arvalid stalls once fifo_count+reserved would exceed 256; no overflow. Release pix_ready → fetch resumes and the frame completes.
- Slave holds arready=0 for 50 cycles with MAX_OUTST=2 → araddr/arlen stable throughout; never more than 2 bursts outstanding.
- Slave returns rresp=2'b10 on one beat → rd_err=1; data still delivered.
- Second frame_start while busy → frame_overrun=1, frame unaffected. Empty FIFO with pix_ready=1 while busy → underrun=1. Reset pulse mid-frame → all outputs back to reset values.

Source files
------------

// File: rtl/vga_frame_fetch.sv
// AXI4 read master: streams a pitched framebuffer into a FWFT pixel FIFO tagged with sol/eof; stats outputs under VGA_FRAME_FETCH_STATS_EN.
// Push-to-pix_valid latency 1 cycle; AR issue stalls until the FIFO can hold every requested beat, so R is always ready while busy.
module vga_frame_fetch #(
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 256,
    parameter int MAX_OUTST  = 2,
    parameter int ARID       = 0
) (
    input  logic              clk,
    input  logic              cpu_resetn,
    input  logic              frame_start,
    input  logic [31:0]       frame_base,
    input  logic [31:0]       line_pitch,
    input  logic [11:0]       line_words,
    input  logic [11:0]       num_lines,
    output logic              busy,
    output logic [7:0]        mem_arid,
    output logic [31:0]       mem_araddr,
    output logic [7:0]        mem_arlen,
    output logic [2:0]        mem_arsize,
    output logic [1:0]        mem_arburst,
    output logic              mem_arlock,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [7:0]        mem_rid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rlast,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sol,
    output logic              pix_eof,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              underrun,
    output logic              rd_err,
    output logic              frame_overrun
`ifdef VGA_FRAME_FETCH_STATS_EN
    ,
    output logic [31:0]       stat_bursts,
    output logic [15:0]       stat_underruns,
    output logic [15:0]       stat_max_lat
`endif
);
    localparam int SIZE = $clog2(DATA_W / 8);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int EW   = DATA_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [11:0] lw_q, lw_d, nl_q, nl_d, word_q, word_d, line_q, line_d, rw_q, rw_d, rl_q, rl_d;
    logic [31:0] pitch_q, pitch_d, line_addr_q, line_addr_d, ar_addr_q, ar_addr_d;
    logic [2:0]  outst_q, outst_d;
    logic [CW-1:0] resv_q, resv_d, cnt_q, cnt_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic        underrun_q, underrun_d, rd_err_q, rd_err_d, overrun_q, overrun_d;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];

    logic [11:0] rem;
    logic [8:0]  beats;
    logic [31:0] ar_step;
    logic        space_ok, ar_vld, ar_hs, r_hs, pop, line_end, last_line;
    logic        push_sol, push_eof, und_cyc;
    logic [EW-1:0] head;
    logic        unused_rid;

    assign unused_rid = ^mem_rid;

    assign rem       = lw_q - word_q;
    assign beats     = (rem > 12'(BURST_LEN)) ? 9'(BURST_LEN) : rem[8:0];
    assign ar_step   = 32'(beats) << SIZE;
    assign space_ok  = (32'(cnt_q) + 32'(resv_q) + 32'(beats)) <= 32'(FIFO_DEPTH);
    assign ar_vld    = (state_q == S_ISSUE) && (32'(outst_q) < 32'(MAX_OUTST)) && space_ok;
    assign ar_hs     = ar_vld & mem_arready;
    assign r_hs      = mem_rvalid & mem_rready;
    assign line_end  = (word_q + 12'(beats)) == lw_q;
    assign last_line = line_q == (nl_q - 12'd1);
    // Tags derive from a return-side counter; single-ID reads come back in order.
    assign push_sol  = rw_q == 12'd0;
    assign push_eof  = (rl_q == (nl_q - 12'd1)) && (rw_q == (lw_q - 12'd1));
    assign head      = fifo_mem[rp_q];
    assign pop       = pix_valid & pix_ready;
    assign und_cyc   = busy & pix_ready & ~pix_valid;

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q     <= S_IDLE;
            lw_q        <= '0;
            nl_q        <= '0;
            word_q      <= '0;
            line_q      <= '0;
            rw_q        <= '0;
            rl_q        <= '0;
            pitch_q     <= '0;
            line_addr_q <= '0;
            ar_addr_q   <= '0;
            outst_q     <= '0;
            resv_q      <= '0;
            cnt_q       <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            underrun_q  <= 1'b0;
            rd_err_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lw_q        <= lw_d;
            nl_q        <= nl_d;
            word_q      <= word_d;
            line_q      <= line_d;
            rw_q        <= rw_d;
            rl_q        <= rl_d;
            pitch_q     <= pitch_d;
            line_addr_q <= line_addr_d;
            ar_addr_q   <= ar_addr_d;
            outst_q     <= outst_d;
            resv_q      <= resv_d;
            cnt_q       <= cnt_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            underrun_q  <= underrun_d;
            rd_err_q    <= rd_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (r_hs) fifo_mem[wp_q] <= {push_sol, push_eof, mem_rdata};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = S_ISSUE;
            S_ISSUE: if (ar_hs && line_end && last_line) state_d = S_DRAIN;
            S_DRAIN: if (outst_d == 3'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = state_q != S_IDLE;
        mem_rready  = state_q != S_IDLE;
        mem_arvalid = ar_vld;
        mem_araddr  = ar_addr_q;
        mem_arlen   = (state_q == S_ISSUE) ? 8'(beats - 9'd1) : 8'd0;
        mem_arid    = 8'(ARID);
        mem_arsize  = 3'(SIZE);
        mem_arburst = 2'b01;
        mem_arlock  = 1'b0;
        pix_valid   = cnt_q != '0;
        pix_data    = pix_valid ? head[DATA_W-1:0] : '0;
        pix_sol     = pix_valid & head[EW-1];
        pix_eof     = pix_valid & head[EW-2];
        underrun      = underrun_q;
        rd_err        = rd_err_q;
        frame_overrun = overrun_q;
    end

    always_comb begin
        lw_d        = lw_q;
        nl_d        = nl_q;
        pitch_d     = pitch_q;
        line_addr_d = line_addr_q;
        ar_addr_d   = ar_addr_q;
        word_d      = word_q;
        line_d      = line_q;
        rw_d        = rw_q;
        rl_d        = rl_q;
        if (state_q == S_IDLE && frame_start) begin
            lw_d        = line_words;
            nl_d        = num_lines;
            pitch_d     = line_pitch;
            line_addr_d = frame_base;
            ar_addr_d   = frame_base;
            word_d      = '0;
            line_d      = '0;
            rw_d        = '0;
            rl_d        = '0;
        end
        // Addresses advance by add only: next burst in line, or next line start.
        if (ar_hs) begin
            if (line_end) begin
                word_d      = '0;
                line_d      = line_q + 12'd1;
                line_addr_d = line_addr_q + pitch_q;
                ar_addr_d   = line_addr_q + pitch_q;
            end else begin
                word_d    = word_q + 12'(beats);
                ar_addr_d = ar_addr_q + ar_step;
            end
        end
        if (r_hs) begin
            if (rw_q == lw_q - 12'd1) begin
                rw_d = '0;
                rl_d = rl_q + 12'd1;
            end else begin
                rw_d = rw_q + 12'd1;
            end
        end
        outst_d    = outst_q + {2'b0, ar_hs} - {2'b0, r_hs & mem_rlast};
        resv_d     = resv_q + (ar_hs ? CW'(beats) : '0) - CW'(r_hs);
        cnt_d      = cnt_q + CW'(r_hs) - CW'(pop);
        wp_d       = wp_q + AW'(r_hs);
        rp_d       = rp_q + AW'(pop);
        underrun_d = underrun_q | und_cyc;
        rd_err_d   = rd_err_q | (r_hs & (mem_rresp != 2'b00));
        overrun_d  = overrun_q | (frame_start & busy);
    end

`ifdef VGA_FRAME_FETCH_STATS_EN
    logic [31:0] st_bursts_q, st_bursts_d;
    logic [15:0] st_under_q, st_under_d, st_lat_q, st_lat_d, tick_q, tick_d, lat;
    logic [15:0] ts_q [4];
    logic [15:0] ts_d [4];
    logic [1:0]  tsw_q, tsw_d, tsr_q, tsr_d;
    logic        first_q, first_d;

    assign lat = tick_q - ts_q[tsr_q];

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            st_bursts_q <= '0;
            st_under_q  <= '0;
            st_lat_q    <= '0;
            tick_q      <= '0;
            tsw_q       <= '0;
            tsr_q       <= '0;
            first_q     <= 1'b1;
            for (int i = 0; i < 4; i++) ts_q[i] <= '0;
        end else begin
            st_bursts_q <= st_bursts_d;
            st_under_q  <= st_under_d;
            st_lat_q    <= st_lat_d;
            tick_q      <= tick_d;
            tsw_q       <= tsw_d;
            tsr_q       <= tsr_d;
            first_q     <= first_d;
            ts_q        <= ts_d;
        end
    end

    // Each AR is timestamped; its first R beat retires the oldest stamp.
    always_comb begin
        st_bursts_d = st_bursts_q;
        st_under_d  = st_under_q;
        st_lat_d    = st_lat_q;
        tick_d      = tick_q + 16'd1;
        tsw_d       = tsw_q;
        tsr_d       = tsr_q;
        first_d     = r_hs ? mem_rlast : first_q;
        ts_d        = ts_q;
        if (ar_hs) begin
            ts_d[tsw_q] = tick_q;
            tsw_d       = tsw_q + 2'd1;
        end
        if (r_hs && first_q) tsr_d = tsr_q + 2'd1;
        if (state_q == S_IDLE && frame_start) begin
            st_bursts_d = '0;
            st_under_d  = '0;
            st_lat_d    = '0;
        end else begin
            if (ar_hs) st_bursts_d = st_bursts_q + 32'd1;
            if (und_cyc && st_under_q != 16'hFFFF) st_under_d = st_under_q + 16'd1;
            if (r_hs && first_q && lat > st_lat_q) st_lat_d = lat;
        end
    end

    assign stat_bursts    = st_bursts_q;
    assign stat_underruns = st_under_q;
    assign stat_max_lat   = st_lat_q;
`endif
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Directed bench for vga_frame_fetch: table of frame configurations plus hand-written stall, overrun/underrun and reset sequences.
module tb_vga_frame_fetch;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        cpu_resetn, frame_start, busy;
    logic [31:0] frame_base, line_pitch;
    logic [11:0] line_words, num_lines;
    logic [7:0]  mem_arid, mem_arlen, mem_rid;
    logic [31:0] mem_araddr, mem_rdata, pix_data;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst, mem_rresp;
    logic        mem_arlock, mem_arvalid, mem_arready, mem_rlast, mem_rvalid, mem_rready;
    logic        pix_sol, pix_eof, pix_valid, pix_ready, underrun, rd_err, frame_overrun;

    always #5 clk = ~clk;

    vga_frame_fetch dut (
        .clk(clk), .cpu_resetn(cpu_resetn), .frame_start(frame_start),
        .frame_base(frame_base), .line_pitch(line_pitch), .line_words(line_words),
        .num_lines(num_lines), .busy(busy), .mem_arid(mem_arid), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
        .mem_arlock(mem_arlock), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rid(mem_rid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .pix_data(pix_data), .pix_sol(pix_sol),
        .pix_eof(pix_eof), .pix_valid(pix_valid), .pix_ready(pix_ready), .underrun(underrun),
        .rd_err(rd_err), .frame_overrun(frame_overrun)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Memory slave: data word = its own byte address, fixed latency, in-order bursts.
    typedef struct { logic [31:0] addr; int len; int rdy; } burst_t;
    burst_t      q[$];
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];
    int cyc = 0, beat = 0, ar_cnt = 0, outst = 0, max_outst = 0, stab_err = 0, stall_seen = 0;
    int err_beat = -1, beat_total = 0, ar_stall = 0, rlast_pre = 0, rlast_post = 0;
    logic        pend = 1'b0, hs_ar, hs_r, busy_pre;
    logic [31:0] s_addr, p_addr;
    logic [7:0]  s_len, p_len;

    initial begin
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        mem_rlast = 1'b0; mem_rid = '0;
        forever begin
            @(negedge clk);
            hs_ar = mem_arvalid && mem_arready;
            hs_r  = mem_rvalid && mem_rready;
            s_addr = mem_araddr; s_len = mem_arlen; busy_pre = busy;
            if (!cpu_resetn) pend = 1'b0;
            else if (pend && (!mem_arvalid || mem_araddr != p_addr || mem_arlen != p_len)) stab_err++;
            pend = cpu_resetn && mem_arvalid && !mem_arready;
            p_addr = mem_araddr; p_len = mem_arlen;
            if (pend) stall_seen++;
            @(posedge clk); #1;
            cyc++;
            if (!cpu_resetn) begin
                q.delete(); beat = 0; outst = 0;
                mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = '0; mem_arready = 1'b0;
                continue;
            end
            if (hs_ar) begin
                q.push_back('{s_addr, int'(s_len), cyc + LAT});
                ar_addr_log.push_back(s_addr); ar_len_log.push_back(int'(s_len));
                ar_cnt++; outst++;
            end
            if (hs_r && q.size() > 0) begin
                beat_total++;
                if (beat == q[0].len) begin
                    void'(q.pop_front());
                    beat = 0; outst--;
                    rlast_pre = int'(busy_pre); rlast_post = int'(busy);
                end else beat++;
            end
            if (outst > max_outst) max_outst = outst;
            if (ar_stall > 0) begin mem_arready = 1'b0; ar_stall--; end
            else mem_arready = 1'b1;
            if (q.size() > 0 && cyc >= q[0].rdy) begin
                mem_rvalid = 1'b1;
                mem_rdata  = q[0].addr + 32'(beat * 4);
                mem_rlast  = (beat == q[0].len);
                mem_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
            end else begin
                mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
            end
        end
    end

    // Consumer scoreboard: expected word = base + line*pitch + 4*word.
    logic [31:0] exp_base = '0, exp_pitch = '0;
    int exp_lw = 1, exp_nl = 1, pix_cnt = 0, pix_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (cpu_resetn && pix_valid && pix_ready) begin
                automatic int l = pix_cnt / exp_lw;
                automatic int w = pix_cnt % exp_lw;
                automatic logic [31:0] ed = exp_base + 32'(l) * exp_pitch + 32'(4 * w);
                if (pix_data !== ed || pix_sol !== (w == 0) || pix_eof !== (pix_cnt == exp_lw * exp_nl - 1))
                    pix_err++;
                pix_cnt++;
            end
        end
    end

    typedef struct {
        logic [31:0] base, pitch;
        int lw, nl, hold, eb, exp_bursts, exp_hold;
        int idx_a; logic [31:0] addr_a; int len_a;
        int idx_b; logic [31:0] addr_b; int len_b;
        int exp_mo; int exp_rderr;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [31:0] p, input int lw, input int nl);
        exp_base = b; exp_pitch = p; exp_lw = lw; exp_nl = nl;
        pix_cnt = 0; pix_err = 0; ar_cnt = 0; max_outst = 0; stab_err = 0; stall_seen = 0;
        beat_total = 0; rlast_pre = 0; rlast_post = 0;
        ar_addr_log.delete(); ar_len_log.delete();
        frame_base = b; line_pitch = p; line_words = 12'(lw); num_lines = 12'(nl);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int total);
        for (int i = 0; i < 6000; i++) begin
            if (pix_cnt == total && !busy) break;
            tick(1);
        end
    endtask

    function automatic logic [31:0] log_addr(input int i);
        return (i < ar_addr_log.size()) ? ar_addr_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int log_len(input int i);
        return (i < ar_len_log.size()) ? ar_len_log[i] : -1;
    endfunction

    initial begin
        vec_t vecs[5];
        int hold_b;
        vecs[0] = '{32'h1000, 32'h400, 640, 2, 400, -1, 80, 16, 39, 32'h19C0, 15, 40, 32'h1400, 15, 2, 0};
        vecs[1] = '{32'h2000, 32'h800,  20, 2, 400, -1,  4,  4,  1, 32'h2040,  3,  2, 32'h2800, 15, 2, 0};
        vecs[2] = '{32'h3000, 32'h040,  16, 4, 400, -1,  4,  4,  1, 32'h3040, 15,  3, 32'h30C0, 15, 2, 0};
        vecs[3] = '{32'h0040, 32'h040,   1, 1, 400, -1,  1,  1,  0, 32'h0040,  0,  0, 32'h0040,  0, 1, 0};
        vecs[4] = '{32'h0000, 32'h100,   8, 3, 400,  5,  3,  3,  1, 32'h0100,  7,  2, 32'h0200,  7, 2, 1};

        cpu_resetn = 1'b0; frame_start = 1'b0; frame_base = '0; line_pitch = '0;
        line_words = '0; num_lines = '0; pix_ready = 1'b0;
        tick(3);
        cpu_resetn = 1'b1;
        tick(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_arvalid", 32'(mem_arvalid), 32'd0);
        chk("rst_rready", 32'(mem_rready), 32'd0);
        chk("rst_araddr", mem_araddr, 32'd0);
        chk("rst_arlen", 32'(mem_arlen), 32'd0);
        chk("rst_arsize", 32'(mem_arsize), 32'd2);
        chk("rst_arburst", 32'(mem_arburst), 32'd1);
        chk("rst_arid", 32'(mem_arid), 32'd0);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_flags", {29'd0, underrun, rd_err, frame_overrun}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            pix_ready = 1'b0; ar_stall = 0; err_beat = vecs[v].eb;
            start_frame(vecs[v].base, vecs[v].pitch, vecs[v].lw, vecs[v].nl);
            tick(vecs[v].hold);
            hold_b = ar_cnt;
            pix_ready = 1'b1;
            wait_done(vecs[v].lw * vecs[v].nl);
            chk($sformatf("v%0d_hold_bursts", v), 32'(hold_b), 32'(vecs[v].exp_hold));
            chk($sformatf("v%0d_bursts", v), 32'(ar_cnt), 32'(vecs[v].exp_bursts));
            chk($sformatf("v%0d_addr_a", v), log_addr(vecs[v].idx_a), vecs[v].addr_a);
            chk($sformatf("v%0d_len_a", v), 32'(log_len(vecs[v].idx_a)), 32'(vecs[v].len_a));
            chk($sformatf("v%0d_addr_b", v), log_addr(vecs[v].idx_b), vecs[v].addr_b);
            chk($sformatf("v%0d_len_b", v), 32'(log_len(vecs[v].idx_b)), 32'(vecs[v].len_b));
            chk($sformatf("v%0d_pix_cnt", v), 32'(pix_cnt), 32'(vecs[v].lw * vecs[v].nl));
            chk($sformatf("v%0d_pix_err", v), 32'(pix_err), 32'd0);
            chk($sformatf("v%0d_busy_fall", v), 32'(rlast_pre * 2 + rlast_post), 32'd2);
            chk($sformatf("v%0d_max_outst", v), 32'(max_outst), 32'(vecs[v].exp_mo));
            chk($sformatf("v%0d_ar_stable", v), 32'(stab_err), 32'd0);
            chk($sformatf("v%0d_rd_err", v), 32'(rd_err), 32'(vecs[v].exp_rderr));
            chk($sformatf("v%0d_underrun", v), 32'(underrun), 32'd0);
            chk($sformatf("v%0d_overrun", v), 32'(frame_overrun), 32'd0);
        end

        // arready held low for 50 cycles: AR must hold, outstanding capped at 2.
        pix_ready = 1'b0; err_beat = -1; ar_stall = 50;
        start_frame(32'h2000, 32'h800, 20, 2);
        tick(400);
        pix_ready = 1'b1;
        wait_done(40);
        chk("stall_seen", 32'(stall_seen >= 45), 32'd1);
        chk("stall_ar_stable", 32'(stab_err), 32'd0);
        chk("stall_max_outst", 32'(max_outst), 32'd2);
        chk("stall_pix_cnt", 32'(pix_cnt), 32'd40);
        chk("stall_pix_err", 32'(pix_err), 32'd0);

        // Consumer ready from the start, plus a second frame_start while busy.
        pix_ready = 1'b1;
        start_frame(32'h2000, 32'h800, 20, 2);
        tick(3);
        frame_base = 32'h9000; line_words = 12'd5;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        wait_done(40);
        chk("ovr_overrun", 32'(frame_overrun), 32'd1);
        chk("ovr_underrun", 32'(underrun), 32'd1);
        chk("ovr_bursts", 32'(ar_cnt), 32'd4);
        chk("ovr_pix_cnt", 32'(pix_cnt), 32'd40);
        chk("ovr_pix_err", 32'(pix_err), 32'd0);

        // Reset mid-frame.
        pix_ready = 1'b0;
        start_frame(32'h1000, 32'h400, 640, 2);
        tick(30);
        chk("mid_busy", 32'(busy), 32'd1);
        cpu_resetn = 1'b0;
        tick(1);
        cpu_resetn = 1'b1;
        tick(2);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_arvalid", 32'(mem_arvalid), 32'd0);
        chk("mrst_rready", 32'(mem_rready), 32'd0);
        chk("mrst_araddr", mem_araddr, 32'd0);
        chk("mrst_pix", {29'd0, pix_valid, pix_sol, pix_eof}, 32'd0);
        chk("mrst_pix_data", pix_data, 32'd0);
        chk("mrst_flags", {29'd0, underrun, rd_err, frame_overrun}, 32'd0);
        chk("mrst_consts", {19'd0, mem_arid, mem_arsize, mem_arburst}, 32'h0000_0009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
